// File: rtl/uart_msg_sender.sv
// Formats a 14-bit reading as an 8-byte ASCII line "D=dddd\r\n" and feeds it byte by byte
// to a UART transmitter using its start_trigger/tx_data/tx_busy handshake.
module uart_msg_sender #(
  parameter logic [7:0] Prefix0 = 8'h44,
  parameter logic [7:0] Prefix1 = 8'h3D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send_req_i,
  input  logic [13:0] value_i,
  input  logic        tx_busy_i,
  output logic        start_trigger_o,
  output logic [7:0]  tx_data_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StConv     = 3'd1;
  localparam logic [2:0] StLoad     = 3'd2;
  localparam logic [2:0] StWaitBusy = 3'd3;
  localparam logic [2:0] StWaitDone = 3'd4;

  localparam logic [13:0] MaxValue  = 14'd9999;
  localparam logic [3:0]  ConvLast  = 4'd13;
  localparam logic [2:0]  LastIdx   = 3'd7;
  localparam logic [7:0]  ByteCr    = 8'h0D;
  localparam logic [7:0]  ByteLf    = 8'h0A;

  logic [2:0]  state_q, state_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [15:0] bcd_adj;
  logic [7:0]  sel_byte;

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Digits are 0..9, so 8'h30 + digit is just the digit in the low nibble.
  always_comb begin
    sel_byte = Prefix0;
    unique case (idx_q)
      3'd0: sel_byte = Prefix0;
      3'd1: sel_byte = Prefix1;
      3'd2: sel_byte = {4'h3, bcd_q[15:12]};
      3'd3: sel_byte = {4'h3, bcd_q[11:8]};
      3'd4: sel_byte = {4'h3, bcd_q[7:4]};
      3'd5: sel_byte = {4'h3, bcd_q[3:0]};
      3'd6: sel_byte = ByteCr;
      3'd7: sel_byte = ByteLf;
    endcase
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    start_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (send_req_i) begin
          bin_d   = (value_i > MaxValue) ? MaxValue : value_i;
          bcd_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = StConv;
        end
      end
      StConv: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == ConvLast) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (!tx_busy_i) begin
          data_d  = sel_byte;
          start_d = 1'b1;
          state_d = StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (tx_busy_i) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (!tx_busy_i) begin
          if (idx_q != LastIdx) begin
            idx_d   = idx_q + 3'd1;
            state_d = StLoad;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign start_trigger_o = start_q;
  assign tx_data_o       = data_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

endmodule
